// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding / load-use hazard controller for the EX-stage ALU operand muxes.
// Keeps a shadow copy of the destination information of the instructions
// currently in EX (EXS) and MEM (MEMS). From those it decides, for the
// instruction leaving ID, where each ALU operand should come from. That
// decision is registered so that it lines up with the instruction once it
// sits in EX.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   id_valid            ID holds a real instruction
//   id_rs / id_rt       source A / B register specifiers
//   id_uses_rs/_rt      instruction actually reads rs / rt
//   id_rd, id_wr_en     destination specifier and its write enable
//   id_is_load          the result is produced by data memory (late)
//   flush               taken branch/jump: squash ID and EX
//   stall               combinational: hold PC and IF/ID, bubble into EX
//   fwdA_sel1/_sel2     operand A mux select {sel1,sel2}:
//                       00 register file, 01 EX/MEM, 10 MEM/WB
//   fwdB_sel1/_sel2     operand B mux select, same encoding
//   stall_count         saturating count of stall cycles since reset
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int REG_ADDR_W  = 6,
  parameter bit ZERO_REG_EN = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wr_en,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic                  stall,
  output logic                  fwdA_sel1,
  output logic                  fwdA_sel2,
  output logic                  fwdB_sel1,
  output logic                  fwdB_sel2,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int NUM_OPS = 2;

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  // EX shadow slot
  logic                  exs_v_q,  exs_v_d;
  logic [REG_ADDR_W-1:0] exs_rd_q, exs_rd_d;
  logic                  exs_wr_q, exs_wr_d;
  logic                  exs_ld_q, exs_ld_d;

  // MEM shadow slot. The load flag is not kept here: once a load has reached
  // MEM its data is forwardable from MEM/WB, so only EX cares about loads.
  logic                  mems_v_q,  mems_v_d;
  logic [REG_ADDR_W-1:0] mems_rd_q, mems_rd_d;
  logic                  mems_wr_q, mems_wr_d;

  logic [1:0]            fwd_a_q, fwd_a_d;
  logic [1:0]            fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]      stall_count_q, stall_count_d;

  // A slot matches a source when it holds a live, writing instruction with
  // that destination. r0 never matches when it is hardwired to zero.
  function automatic logic slot_match(
    input logic                  v,
    input logic                  wr,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] src
  );
    return v & wr & (rd == src) & ~(ZERO_REG_EN & (src == '0));
  endfunction

  // Per-operand view of the ID instruction
  logic [REG_ADDR_W-1:0] op_reg     [NUM_OPS];
  logic                  op_use     [NUM_OPS];
  logic                  op_hit_ex  [NUM_OPS];
  logic                  op_hit_mem [NUM_OPS];
  logic [1:0]            op_sel     [NUM_OPS];

  assign op_reg[0] = id_rs;
  assign op_reg[1] = id_rt;
  assign op_use[0] = id_uses_rs;
  assign op_use[1] = id_uses_rt;

  generate
    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op
      assign op_hit_ex[gi]  = op_use[gi] &
                              slot_match(exs_v_q, exs_wr_q, exs_rd_q, op_reg[gi]);
      assign op_hit_mem[gi] = op_use[gi] &
                              slot_match(mems_v_q, mems_wr_q, mems_rd_q, op_reg[gi]);
      // The EX slot holds the younger producer, so it wins over MEM.
      assign op_sel[gi] = op_hit_ex[gi]  ? SEL_EXMEM :
                          op_hit_mem[gi] ? SEL_MEMWB : SEL_RF;
    end
  endgenerate

  // A load in EX has no data yet for a consumer entering EX next cycle.
  // A flush squashes the consumer anyway, so it suppresses the stall.
  assign stall = id_valid & ~flush & exs_ld_q & (op_hit_ex[0] | op_hit_ex[1]);

  always_comb begin
    // The MEM slot always follows EX; EX is never held, only bubbled.
    mems_v_d      = exs_v_q;
    mems_rd_d     = exs_rd_q;
    mems_wr_d     = exs_wr_q;

    exs_v_d       = id_valid;
    exs_rd_d      = id_rd;
    exs_wr_d      = id_wr_en;
    exs_ld_d      = id_is_load;
    fwd_a_d       = op_sel[0];
    fwd_b_d       = op_sel[1];
    stall_count_d = stall_count_q;

    if (flush || stall) begin
      exs_v_d  = 1'b0;
      exs_rd_d = '0;
      exs_wr_d = 1'b0;
      exs_ld_d = 1'b0;
      fwd_a_d  = SEL_RF;
      fwd_b_d  = SEL_RF;
    end

    if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exs_v_q       <= 1'b0;
      exs_rd_q      <= '0;
      exs_wr_q      <= 1'b0;
      exs_ld_q      <= 1'b0;
      mems_v_q      <= 1'b0;
      mems_rd_q     <= '0;
      mems_wr_q     <= 1'b0;
      fwd_a_q       <= SEL_RF;
      fwd_b_q       <= SEL_RF;
      stall_count_q <= '0;
    end else begin
      exs_v_q       <= exs_v_d;
      exs_rd_q      <= exs_rd_d;
      exs_wr_q      <= exs_wr_d;
      exs_ld_q      <= exs_ld_d;
      mems_v_q      <= mems_v_d;
      mems_rd_q     <= mems_rd_d;
      mems_wr_q     <= mems_wr_d;
      fwd_a_q       <= fwd_a_d;
      fwd_b_q       <= fwd_b_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fwdA_sel1   = fwd_a_q[1];
  assign fwdA_sel2   = fwd_a_q[0];
  assign fwdB_sel1   = fwd_b_q[1];
  assign fwdB_sel2   = fwd_b_q[0];
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
//
// Drives fwd_hazard_unit with directed instruction sequences and a random
// run. A reference model tracks the in-flight producers as a two-entry
// history (youngest first) and derives the stall, operand sources and stall
// count from it. A second instance with a 4-bit counter exercises counter
// saturation within a short run.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [5:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rs, id_uses_rt, id_wr_en, id_is_load, flush;
  logic        stall, fa1, fa2, fb1, fb2;
  logic [15:0] stall_count;
  logic        stall_s, fa1_s, fa2_s, fb1_s, fb2_s;
  logic [3:0]  count_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
    .stall(stall), .fwdA_sel1(fa1), .fwdA_sel2(fa2), .fwdB_sel1(fb1),
    .fwdB_sel2(fb2), .stall_count(stall_count)
  );

  fwd_hazard_unit #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
    .stall(stall_s), .fwdA_sel1(fa1_s), .fwdA_sel2(fa2_s), .fwdB_sel1(fb1_s),
    .fwdB_sel2(fb2_s), .stall_count(count_s)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit v;
    bit wr;
    bit ld;
    int rd;
  } slot_t;

  slot_t    pipe [2];      // [0] producer now in EX, [1] producer now in MEM
  bit [1:0] exp_a = 2'b00;
  bit [1:0] exp_b = 2'b00;
  int       stall_total = 0;

  function automatic bit m_match(slot_t s, int x);
    return s.v && s.wr && (s.rd == x) && (x != 0);
  endfunction

  function automatic bit m_stall();
    if (!id_valid || flush || !pipe[0].ld) return 1'b0;
    return (id_uses_rs && m_match(pipe[0], int'(id_rs))) ||
           (id_uses_rt && m_match(pipe[0], int'(id_rt)));
  endfunction

  // Youngest matching producer decides the source: EX -> 01, MEM -> 10.
  function automatic bit [1:0] m_sel(bit used, int x);
    if (!used) return 2'b00;
    for (int i = 0; i < 2; i++)
      if (m_match(pipe[i], x)) return 2'(i + 1);
    return 2'b00;
  endfunction

  function automatic int sat_expect();
    return (stall_total > 15) ? 15 : stall_total;
  endfunction

  task automatic tick();
    bit       st;
    bit [1:0] na, nb;
    st = m_stall();
    na = m_sel(id_uses_rs, int'(id_rs));
    nb = m_sel(id_uses_rt, int'(id_rt));
    if (rst) begin
      pipe[0] = '{default: 0};
      pipe[1] = '{default: 0};
      exp_a = 2'b00;
      exp_b = 2'b00;
      stall_total = 0;
    end else begin
      pipe[1] = pipe[0];
      if (flush || st) begin
        pipe[0] = '{default: 0};
        exp_a = 2'b00;
        exp_b = 2'b00;
        if (st) stall_total++;
      end else begin
        pipe[0] = '{v: id_valid, wr: id_wr_en, ld: id_is_load, rd: int'(id_rd)};
        exp_a = na;
        exp_b = nb;
      end
    end
    @(posedge clk);
    #1;
    $display("t=%0t rst=%b v=%b rs=%0d rt=%0d rd=%0d wr=%b ld=%b fl=%b | stall_was=%b A=%b%b B=%b%b cnt=%0d",
             $time, rst, id_valid, id_rs, id_rt, id_rd, id_wr_en, id_is_load,
             flush, st, fa1, fa2, fb1, fb2, stall_count);
  endtask

  task automatic issue(input bit v, input int rs, input int rt, input bit urs,
                       input bit urt, input int rd, input bit wr, input bit ld,
                       input bit fl);
    id_valid   = v;
    id_rs      = 6'(rs);
    id_rt      = 6'(rt);
    id_uses_rs = urs;
    id_uses_rt = urt;
    id_rd      = 6'(rd);
    id_wr_en   = wr;
    id_is_load = ld;
    flush      = fl;
    #1;
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nop();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    issue(1, 3, 3, 1, 1, 3, 1, 1, 0);
    tick();
    tick();
    n_cmp++;
    if ({stall, fa1, fa2, fb1, fb2} !== 5'b0 || stall_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_state got stall=%b sels=%b%b%b%b cnt=%0d required all zero",
               stall, fa1, fa2, fb1, fb2, stall_count);
    end
    rst = 1'b0;
    nop();
  endtask

  task automatic test_fwd_ex();
    do_reset();
    issue(1, 1, 2, 1, 1, 3, 1, 0, 0);    // ADD r3,r1,r2
    tick();
    issue(1, 3, 5, 1, 1, 4, 1, 0, 0);    // SUB r4,r3,r5
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL fwd_ex_stall got=%b required=0", stall);
    end
    tick();
    n_cmp++;
    if ({fa1, fa2, fb1, fb2} !== {exp_a, exp_b} || {exp_a, exp_b} !== 4'b0100) begin
      n_bad++;
      $display("FAIL fwd_ex_sels got=%b%b%b%b required=%b%b (expect 0100)",
               fa1, fa2, fb1, fb2, exp_a, exp_b);
    end
    nop();
  endtask

  task automatic test_fwd_mem();
    do_reset();
    issue(1, 1, 2, 1, 1, 3, 1, 0, 0);    // ADD r3
    tick();
    nop();
    tick();
    issue(1, 9, 3, 1, 1, 10, 1, 0, 0);   // use r3 as rt
    tick();
    n_cmp++;
    if ({fa1, fa2, fb1, fb2} !== {exp_a, exp_b} || {exp_a, exp_b} !== 4'b0010) begin
      n_bad++;
      $display("FAIL fwd_mem_sels got=%b%b%b%b required=%b%b",
               fa1, fa2, fb1, fb2, exp_a, exp_b);
    end
    nop();
  endtask

  task automatic test_load_use();
    do_reset();
    issue(1, 1, 0, 1, 0, 7, 1, 1, 0);    // LD r7
    tick();
    issue(1, 7, 7, 1, 1, 8, 1, 0, 0);    // ADD r8,r7,r7
    n_cmp++;
    if (stall !== m_stall() || stall !== 1'b1) begin
      n_bad++;
      $display("FAIL load_use_stall got=%b required=1", stall);
    end
    tick();
    n_cmp++;
    if (stall !== m_stall() || stall !== 1'b0) begin
      n_bad++;
      $display("FAIL load_use_one_cycle got=%b required=0", stall);
    end
    n_cmp++;
    if ({fa1, fa2, fb1, fb2} !== {exp_a, exp_b}) begin
      n_bad++;
      $display("FAIL load_use_bubble_sels got=%b%b%b%b required=%b%b",
               fa1, fa2, fb1, fb2, exp_a, exp_b);
    end
    tick();
    n_cmp++;
    if ({fa1, fa2, fb1, fb2} !== {exp_a, exp_b} || {exp_a, exp_b} !== 4'b1010) begin
      n_bad++;
      $display("FAIL load_use_sels got=%b%b%b%b required=%b%b",
               fa1, fa2, fb1, fb2, exp_a, exp_b);
    end
    n_cmp++;
    if (stall_count !== 16'(stall_total) || stall_total != 1) begin
      n_bad++;
      $display("FAIL load_use_count got=%0d required=%0d", stall_count, stall_total);
    end
    nop();
  endtask

  task automatic test_younger_wins();
    do_reset();
    issue(1, 1, 1, 1, 1, 2, 1, 0, 0);    // ADD r2
    tick();
    issue(1, 4, 5, 1, 1, 2, 1, 0, 0);    // ADD r2 again
    tick();
    issue(1, 2, 2, 1, 1, 6, 1, 0, 0);    // use r2 twice
    tick();
    n_cmp++;
    if ({fa1, fa2, fb1, fb2} !== {exp_a, exp_b} || {exp_a, exp_b} !== 4'b0101) begin
      n_bad++;
      $display("FAIL younger_wins got=%b%b%b%b required=%b%b",
               fa1, fa2, fb1, fb2, exp_a, exp_b);
    end
    nop();
  endtask

  task automatic test_zero_reg();
    do_reset();
    issue(1, 1, 2, 1, 1, 0, 1, 0, 0);    // write r0
    tick();
    issue(1, 0, 0, 1, 1, 5, 1, 0, 0);    // read r0 twice
    tick();
    n_cmp++;
    if ({fa1, fa2, fb1, fb2} !== {exp_a, exp_b} || {exp_a, exp_b} !== 4'b0000) begin
      n_bad++;
      $display("FAIL zero_reg got=%b%b%b%b required=%b%b",
               fa1, fa2, fb1, fb2, exp_a, exp_b);
    end
    issue(1, 1, 1, 1, 1, 0, 1, 1, 0);    // load into r0
    tick();
    issue(1, 0, 0, 1, 1, 5, 1, 0, 0);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_reg_stall got=%b required=0", stall);
    end
    tick();
    nop();
  endtask

  task automatic test_flush();
    do_reset();
    issue(1, 1, 0, 1, 0, 7, 1, 1, 0);    // LD r7
    tick();
    issue(1, 7, 0, 1, 0, 8, 1, 0, 1);    // use r7 under flush
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_stall got=%b required=0", stall);
    end
    tick();
    n_cmp++;
    if ({fa1, fa2, fb1, fb2} !== 4'b0000) begin
      n_bad++;
      $display("FAIL flush_sels got=%b%b%b%b required=0000", fa1, fa2, fb1, fb2);
    end
    // EX now holds a bubble; the load is in MEM and is forwarded with no stall.
    issue(1, 7, 7, 1, 1, 9, 1, 0, 0);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_bubble_stall got=%b required=0", stall);
    end
    tick();
    n_cmp++;
    if ({fa1, fa2, fb1, fb2} !== {exp_a, exp_b} || {exp_a, exp_b} !== 4'b1010) begin
      n_bad++;
      $display("FAIL flush_bubble_sels got=%b%b%b%b required=%b%b",
               fa1, fa2, fb1, fb2, exp_a, exp_b);
    end
    nop();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    issue(1, 1, 0, 1, 0, 7, 1, 1, 0);    // LD r7
    tick();
    issue(1, 7, 7, 1, 1, 8, 1, 0, 0);
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_stall_setup got=%b required=1", stall);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({stall, fa1, fa2, fb1, fb2} !== 5'b0 || stall_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_mid_stall got stall=%b sels=%b%b%b%b cnt=%0d required all zero",
               stall, fa1, fa2, fb1, fb2, stall_count);
    end
    nop();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      issue($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 4) != 0,
            $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
      n_cmp++;
      if (stall !== m_stall()) begin
        n_bad++;
        $display("FAIL rand_stall[%0d] got=%b required=%b", i, stall, m_stall());
      end
      tick();
      n_cmp++;
      if ({fa1, fa2, fb1, fb2} !== {exp_a, exp_b} || stall_count !== 16'(stall_total)) begin
        n_bad++;
        $display("FAIL rand_out[%0d] got sels=%b%b%b%b cnt=%0d required sels=%b%b cnt=%0d",
                 i, fa1, fa2, fb1, fb2, stall_count, exp_a, exp_b, stall_total);
      end
    end
    rst = 1'b0;
    nop();
  endtask

  task automatic test_saturation();
    int cyc;
    do_reset();
    cyc = 0;
    // LD r7 <- [r7] repeated: every second cycle is a load-use stall.
    while (stall_total < 19 && cyc < 100) begin
      issue(1, 7, 0, 1, 0, 7, 1, 1, 0);
      n_cmp++;
      if (stall_s !== m_stall() || stall !== m_stall()) begin
        n_bad++;
        $display("FAIL sat_stall[%0d] got=%b/%b required=%b", cyc, stall, stall_s, m_stall());
      end
      tick();
      n_cmp++;
      if (count_s !== 4'(sat_expect())) begin
        n_bad++;
        $display("FAIL sat_count[%0d] got=%0d required=%0d", cyc, count_s, sat_expect());
      end
      cyc++;
    end
    n_cmp++;
    if (stall_total != 19 || count_s !== 4'hF || stall_count !== 16'd19) begin
      n_bad++;
      $display("FAIL sat_final got small=%0d wide=%0d model=%0d required 15/19",
               count_s, stall_count, stall_total);
    end
    nop();
  endtask

  initial begin
    rst = 1'b1;
    nop();
    pipe[0] = '{default: 0};
    pipe[1] = '{default: 0};
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_load_use();
    test_younger_wins();
    test_zero_reg();
    test_flush();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
